dual_port_ram_param: RTL and testbench
======================================

Name: dual_port_ram_param

Overview:
Parametrised single-clock simple dual-port RAM: one write port and one read port sharing one clock. It is the next-generation replacement for the fixed 8x16 dual-port RAM in the memory library. Additions over the fixed block:
- configurable width and depth
- hardware initialisation sequencer that clears the array after reset or on request
- selectable read-during-write policy
- optional output register
- read-valid strobe and dropped-write indication

Parameters:
DATA_W, 16, data width in bits (>=1)
ADDR_W, 3, address width; DEPTH = 2**ADDR_W words
RDW_MODE, 0, same-address read/write collision: 0 = read returns old data, 1 = write-through (returns data_w)
OUT_REG, 0, 1 adds an output pipeline register (read latency 2 instead of 1)
INIT_VAL, 0, DATA_W-bit value written to every word by the init sequencer

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
clr  in  1  synchronous request to re-run the init sequencer
busy  out  1  high while the init sequencer owns the array
we  in  1  write enable
addr_w  in  ADDR_W  write address
data_w  in  DATA_W  write data
re  in  1  read enable
addr_r  in  ADDR_W  read address
data_r  out  DATA_W  read data; holds its last value between reads
rvalid  out  1  one-cycle strobe, data_r updated this cycle
wr_drop  out  1  one-cycle strobe, a write request was discarded

Behaviour:
Reset:
- rst_n low asynchronously forces: FSM=INIT, init counter=0, busy=1, data_r=0, rvalid=0, wr_drop=0, OUT_REG stage cleared (data 0, valid 0).
- The array itself is not reset asynchronously; the sequencer clears it.

FSM states:
- INIT:
  - Each clock writes INIT_VAL to mem[cnt], then cnt+1.
  - After writing DEPTH-1, go to READY.
  - busy=1 for exactly DEPTH cycles after the first rising edge with rst_n high, then 0.
  - clr while in INIT is ignored; the counter does not restart.
- READY:
  - busy=0.
  - clr=1 moves to INIT with cnt=0; busy rises on the next cycle.

Writes:
- In READY with we=1 and clr=0: mem[addr_w] <= data_w at the edge.
- In INIT, or in READY with clr=1: the write is discarded and wr_drop=1 in the following cycle.

Reads:
- Accepted when re=1 and the FSM is READY, including the cycle clr is sampled; that read returns pre-clear contents.
- Accepted at edge N:
  - OUT_REG=0: data_r and rvalid update at edge N (latency 1).
  - OUT_REG=1: they update at edge N+1 (latency 2).
- rvalid is high for one cycle per accepted read. Back-to-back reads give continuous rvalid, full throughput.
- re during INIT is ignored; no rvalid; data_r holds.

Collision (accepted read and accepted write, addr_r==addr_w, same edge):
- RDW_MODE=0 returns the previous contents.
- RDW_MODE=1 returns data_w.
- The array is written in both modes.

Reset mid-operation:
- In-flight reads are lost: rvalid is not asserted for them.
- The sequencer restarts from address 0 after rst_n releases.

Test Plan:
1. rst_n low 3 cycles then high, idle inputs (DEPTH=8) -> busy high exactly 8 cycles; then reads of addr 0..7 return 0x0000 each with rvalid one cycle after re.
2. Write 0xA5A5 to addr 3, then read addr 3 -> data_r=0xA5A5 with rvalid latency 1 (OUT_REG=0) or 2 (OUT_REG=1); data_r holds 0xA5A5 after rvalid drops.
3. mem[5]=0x1111, then same-edge we=1 addr_w=5 data_w=0x2222, re=1 addr_r=5 -> data_r=0x1111 (RDW_MODE=0) or 0x2222 (RDW_MODE=1); a following read of addr 5 returns 0x2222.
4. In READY: assert clr with we=1 data_w=0xBEEF addr_w=1 -> wr_drop pulses; busy high 8 cycles; addr 1 then reads 0x0000. we during busy -> wr_drop pulses each such cycle; re during busy -> no rvalid.
5. Back-to-back reads of addr 0..7 after writing 0x0010..0x0017 -> rvalid high 8 consecutive cycles, data sequence 0x0010..0x0017 in order.
6. Issue re, then assert rst_n low before the data returns (OUT_REG=1) -> rvalid never asserts, data_r=0; after release the init sequence repeats and busy is high 8 cycles.

Source files
------------

// File: rtl/dual_port_ram_param_if.sv
// dual_port_ram_param_if: write/read/control bundle for the parametrised dual-port RAM
interface dual_port_ram_param_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic              clr;
    logic              busy;
    logic              we;
    logic [ADDR_W-1:0] addr_w;
    logic [DATA_W-1:0] data_w;
    logic              re;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] data_r;
    logic              rvalid;
    logic              wr_drop;
    modport master (
        output clr, we, addr_w, data_w, re, addr_r,
        input  busy, data_r, rvalid, wr_drop
    );
    modport slave (
        input  clr, we, addr_w, data_w, re, addr_r,
        output busy, data_r, rvalid, wr_drop
    );
endinterface

// File: rtl/dual_port_ram_param.sv
// dual_port_ram_param: single-clock simple dual-port RAM with init sequencer and optional output register
module dual_port_ram_param #(
    parameter int              DATA_W   = 16,
    parameter int              ADDR_W   = 3,
    parameter int              RDW_MODE = 0,
    parameter int              OUT_REG  = 0,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input logic                  clk,
    input logic                  rst_n,
    dual_port_ram_param_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    typedef enum logic {INIT, READY} state_t;
    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;
    logic              busy, wr_acc, rd_acc, p_valid, src_v, rvalid, wr_drop;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd, p_data, src_d, data_r;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end
    always_comb begin
        busy      = state == INIT;
        wr_acc    = !busy && bus.we && !bus.clr;
        rd_acc    = !busy && bus.re;
        state_nxt = busy ? (&cnt ? READY : INIT) : (bus.clr ? INIT : READY);
        cnt_nxt   = busy ? cnt + ADDR_W'(1) : '0;
        rd        = (RDW_MODE != 0 && wr_acc && bus.addr_w == bus.addr_r) ? bus.data_w : mem[bus.addr_r];
        src_v     = OUT_REG != 0 ? p_valid : rd_acc;
        src_d     = OUT_REG != 0 ? p_data : rd;
    end
    // sequencer owns the array while busy; user writes only land in READY
    always_ff @(posedge clk) begin
        if (busy)
            mem[cnt] <= INIT_VAL;
        else if (wr_acc)
            mem[bus.addr_w] <= bus.data_w;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_valid <= 1'b0;
            p_data  <= '0;
            rvalid  <= 1'b0;
            data_r  <= '0;
            wr_drop <= 1'b0;
        end else begin
            p_valid <= rd_acc;
            if (rd_acc)
                p_data <= rd;
            rvalid <= src_v;
            if (src_v)
                data_r <= src_d;
            wr_drop <= bus.we && !wr_acc;
        end
    end
    assign bus.busy    = busy;
    assign bus.data_r  = data_r;
    assign bus.rvalid  = rvalid;
    assign bus.wr_drop = wr_drop;
endmodule

// File: tb/tb_dual_port_ram_param.sv
// tb_dual_port_ram_param: table-driven check of two RAM variants (old-data/latency 1 and write-through/latency 2)
module tb_dual_port_ram_param;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0, we = 1'b0, re = 1'b0;
    logic [2:0]  aw = '0, ar = '0;
    logic [15:0] dw = '0;
    int          errors = 0, checks = 0;

    always #5 clk = ~clk;

    dual_port_ram_param_if #(.DATA_W(16), .ADDR_W(3)) b0 ();
    dual_port_ram_param_if #(.DATA_W(16), .ADDR_W(3)) b1 ();

    assign b0.clr = clr;
    assign b0.we = we;
    assign b0.addr_w = aw;
    assign b0.data_w = dw;
    assign b0.re = re;
    assign b0.addr_r = ar;
    assign b1.clr = clr;
    assign b1.we = we;
    assign b1.addr_w = aw;
    assign b1.data_w = dw;
    assign b1.re = re;
    assign b1.addr_r = ar;

    dual_port_ram_param #(.DATA_W(16), .ADDR_W(3), .RDW_MODE(0), .OUT_REG(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    dual_port_ram_param #(.DATA_W(16), .ADDR_W(3), .RDW_MODE(1), .OUT_REG(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));

    typedef struct {
        logic        clr, we;
        logic [2:0]  aw;
        logic [15:0] dw;
        logic        re;
        logic [2:0]  ar;
        logic        busy, drop, rv0;
        logic [15:0] d0;
        logic        rv1;
        logic [15:0] d1;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic c, logic w, logic [2:0] a_w, logic [15:0] d_w, logic r, logic [2:0] a_r,
                                logic b, logic dr, logic v0, logic [15:0] e0, logic v1, logic [15:0] e1);
        vec_t v;
        v.clr = c; v.we = w; v.aw = a_w; v.dw = d_w; v.re = r; v.ar = a_r;
        v.busy = b; v.drop = dr; v.rv0 = v0; v.d0 = e0; v.rv1 = v1; v.d1 = e1;
        return v;
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask

    task automatic drive(input logic c, input logic w, input logic [2:0] a_w, input logic [15:0] d_w,
                         input logic r, input logic [2:0] a_r);
        clr = c; we = w; aw = a_w; dw = d_w; re = r; ar = a_r;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic count_init(input string n);
        int n0, n1, rv;
        n0 = 0; n1 = 0; rv = 0;
        for (int k = 0; k < 12; k++) begin
            n0 += int'(b0.busy);
            n1 += int'(b1.busy);
            rv += int'(b0.rvalid) + int'(b1.rvalid);
            step();
        end
        chk({n, " busy0 cycles"}, n0, 8);
        chk({n, " busy1 cycles"}, n1, 8);
        chk({n, " rvalid during init"}, rv, 0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(0, 0, 0, 0, 1, 3'(i), 0, 0, 1, 16'h0000, i > 0, 16'h0000));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 1, 16'h0000));
        tbl.push_back(mk(0, 1, 3, 16'hA5A5, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000));
        tbl.push_back(mk(0, 0, 0, 0, 1, 3, 0, 0, 1, 16'hA5A5, 0, 16'h0000));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'hA5A5, 1, 16'hA5A5));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'hA5A5, 0, 16'hA5A5));
        tbl.push_back(mk(0, 1, 5, 16'h1111, 0, 0, 0, 0, 0, 16'hA5A5, 0, 16'hA5A5));
        tbl.push_back(mk(0, 1, 5, 16'h2222, 1, 5, 0, 0, 1, 16'h1111, 0, 16'hA5A5));
        tbl.push_back(mk(0, 0, 0, 0, 1, 5, 0, 0, 1, 16'h2222, 1, 16'h2222));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h2222, 1, 16'h2222));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(0, 1, 3'(i), 16'(16 + i), 0, 0, 0, 0, 0, 16'h2222, 0, 16'h2222));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(0, 0, 0, 0, 1, 3'(i), 0, 0, 1, 16'(16 + i), i > 0, i > 0 ? 16'(15 + i) : 16'h2222));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0017, 1, 16'h0017));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0017, 0, 16'h0017));
        tbl.push_back(mk(1, 1, 1, 16'hBEEF, 1, 2, 1, 1, 1, 16'h0012, 0, 16'h0017));
        tbl.push_back(mk(0, 1, 4, 16'h3333, 1, 4, 1, 1, 0, 16'h0012, 1, 16'h0012));
        tbl.push_back(mk(0, 1, 0, 16'h4444, 1, 0, 1, 1, 0, 16'h0012, 0, 16'h0012));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0012, 0, 16'h0012));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0012, 0, 16'h0012));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0012, 0, 16'h0012));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 1, 16'h0000, 0, 16'h0012));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 16'h0000, 1, 16'h0000));
        tbl.push_back(mk(0, 0, 0, 0, 1, 4, 0, 0, 1, 16'h0000, 1, 16'h0000));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 1, 16'h0000));

        repeat (3) step();
        chk("rst busy0", b0.busy, 1);
        chk("rst busy1", b1.busy, 1);
        chk("rst rvalid0", b0.rvalid, 0);
        chk("rst rvalid1", b1.rvalid, 0);
        chk("rst data0", b0.data_r, 0);
        chk("rst data1", b1.data_r, 0);
        chk("rst drop0", b0.wr_drop, 0);
        chk("rst drop1", b1.wr_drop, 0);
        rst_n = 1'b1;
        count_init("init");

        foreach (tbl[i]) begin
            drive(tbl[i].clr, tbl[i].we, tbl[i].aw, tbl[i].dw, tbl[i].re, tbl[i].ar);
            step();
            chk($sformatf("v%0d busy0", i), b0.busy, tbl[i].busy);
            chk($sformatf("v%0d busy1", i), b1.busy, tbl[i].busy);
            chk($sformatf("v%0d drop0", i), b0.wr_drop, tbl[i].drop);
            chk($sformatf("v%0d drop1", i), b1.wr_drop, tbl[i].drop);
            chk($sformatf("v%0d rvalid0", i), b0.rvalid, tbl[i].rv0);
            chk($sformatf("v%0d data0", i), b0.data_r, tbl[i].d0);
            chk($sformatf("v%0d rvalid1", i), b1.rvalid, tbl[i].rv1);
            chk($sformatf("v%0d data1", i), b1.data_r, tbl[i].d1);
        end

        drive(0, 1, 6, 16'h5A5A, 0, 0);
        step();
        drive(0, 0, 0, 0, 1, 6);
        step();
        chk("midrst pre rvalid0", b0.rvalid, 1);
        chk("midrst pre data0", b0.data_r, 16'h5A5A);
        chk("midrst pre rvalid1", b1.rvalid, 0);
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst async rvalid1", b1.rvalid, 0);
        chk("midrst async data1", b1.data_r, 0);
        chk("midrst async data0", b0.data_r, 0);
        chk("midrst async busy1", b1.busy, 1);
        step();
        chk("midrst held rvalid1", b1.rvalid, 0);
        step();
        rst_n = 1'b1;
        count_init("reinit");
        drive(0, 0, 0, 0, 1, 6);
        step();
        drive(0, 0, 0, 0, 0, 0);
        chk("post rvalid0", b0.rvalid, 1);
        chk("post data0", b0.data_r, 0);
        chk("post rvalid1 early", b1.rvalid, 0);
        step();
        chk("post rvalid1", b1.rvalid, 1);
        chk("post data1", b1.data_r, 0);
        chk("post rvalid0 drop", b0.rvalid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
